// File: rtl/genius_control_if.sv
// Handshake/status bundle between genius_control and its surroundings
// (input synchronizers, Reg_setup, sequence display and scoring).
interface genius_control_if #(
    parameter int p_round = 4,
    parameter int p_setup = 2
);
    logic               enter;
    logic               tick;
    logic               user_key;
    logic               match;
    logic [p_setup-1:0] reg_setup_level;
    logic [p_round-1:0] round;
    logic [p_round-1:0] seq_idx;
    logic               show;
    logic               setup_en;
    logic [2:0]         state;
    logic               done;
    logic               win;

    modport master (
        output enter, tick, user_key, match, reg_setup_level,
        input  round, seq_idx, show, setup_en, state, done, win
    );

    modport slave (
        input  enter, tick, user_key, match, reg_setup_level,
        output round, seq_idx, show, setup_en, state, done, win
    );
endinterface

// File: rtl/genius_control.sv
// Memory-game sequencing FSM: setup, show growing sequence, check presses.
// Define GENIUS_TIMEOUT_EN to compile in the per-level INPUT timeout.
module genius_control #(
    parameter int p_round = 4,
    parameter int p_setup = 2,
    parameter int p_tmo   = 4
) (
    input logic              clock,
    input logic              reset,
    genius_control_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHOW   = 3'd2,
        INPUT  = 3'd3,
        NEXT   = 3'd4,
        RESULT = 3'd5
    } state_t;

    localparam logic [p_round-1:0] one_r      = {{(p_round-1){1'b0}}, 1'b1};
    localparam logic [p_round-1:0] last_round = {{(p_round-1){1'b1}}, 1'b0};

    state_t             state_q, state_nx;
    logic [p_round-1:0] round_q, round_nx;
    logic [p_round-1:0] idx_q, idx_nx;
    logic               win_q, win_nx;

`ifdef GENIUS_TIMEOUT_EN
    localparam logic [p_tmo-1:0] one_t = {{(p_tmo-1){1'b0}}, 1'b1};

    logic [p_tmo-1:0] tmo_q, tmo_nx, tmo_inc, tmo_limit;

    assign tmo_inc = tmo_q + one_t;

    always_comb begin
        case (bus.reg_setup_level)
            2'd0:    tmo_limit = p_tmo'(8);
            2'd1:    tmo_limit = p_tmo'(6);
            2'd2:    tmo_limit = p_tmo'(4);
            default: tmo_limit = p_tmo'(2);
        endcase
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            idx_q   <= '0;
            win_q   <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_nx;
            round_q <= round_nx;
            idx_q   <= idx_nx;
            win_q   <= win_nx;
`ifdef GENIUS_TIMEOUT_EN
            tmo_q   <= tmo_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state_q;
        round_nx = round_q;
        idx_nx   = idx_q;
        win_nx   = win_q;
`ifdef GENIUS_TIMEOUT_EN
        // Counter is held at zero outside INPUT, so it starts clean on entry.
        tmo_nx   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.enter) state_nx = SETUP;
            end
            SETUP: begin
                round_nx = '0;
                idx_nx   = '0;
                win_nx   = 1'b0;
                state_nx = SHOW;
            end
            SHOW: begin
                if (bus.tick) begin
                    if (idx_q == round_q) begin
                        idx_nx   = '0;
                        state_nx = INPUT;
                    end else begin
                        idx_nx = idx_q + one_r;
                    end
                end
            end
            INPUT: begin
`ifdef GENIUS_TIMEOUT_EN
                tmo_nx = tmo_q;
`endif
                // A key press wins over a simultaneous tick.
                if (bus.user_key) begin
`ifdef GENIUS_TIMEOUT_EN
                    tmo_nx = '0;
`endif
                    if (!bus.match) begin
                        win_nx   = 1'b0;
                        state_nx = RESULT;
                    end else if (idx_q == round_q) begin
                        state_nx = NEXT;
                    end else begin
                        idx_nx = idx_q + one_r;
                    end
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (bus.tick) begin
                    tmo_nx = tmo_inc;
                    if (tmo_inc >= tmo_limit) begin
                        win_nx   = 1'b0;
                        state_nx = RESULT;
                    end
                end
`endif
            end
            NEXT: begin
                round_nx = round_q + one_r;
                idx_nx   = '0;
                if (round_q == last_round) begin
                    win_nx   = 1'b1;
                    state_nx = RESULT;
                end else begin
                    state_nx = SHOW;
                end
            end
            RESULT: begin
                if (bus.enter) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.state    = state_q;
    assign bus.round    = round_q;
    assign bus.seq_idx  = idx_q;
    assign bus.win      = win_q;
    assign bus.show     = (state_q == SHOW);
    assign bus.setup_en = (state_q == SETUP);
    assign bus.done     = (state_q == RESULT);
endmodule

// File: tb/tb_genius_control.sv
// Self-checking bench for genius_control: vector table, scoreboard queue,
// and hand-written sequences for timeout, full win and mid-game reset.
module tb_genius_control;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    genius_control_if #(.p_round(4), .p_setup(2)) bus ();

    genius_control #(.p_round(4), .p_setup(2), .p_tmo(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    typedef struct {
        logic       e, t, k, m;
        logic [2:0] st;
        logic [3:0] rd, id;
        logic       w;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] exp;
        logic [14:0] mask;
    } sb_t;

    localparam logic [14:0] full_m  = 15'h7FFF;
    localparam logic [14:0] state_m = 15'h700E;

    sb_t  sbq[$];
    vec_t tbl[30];

    function automatic logic [14:0] pack(input logic [2:0] st, input logic [3:0] rd,
                                         input logic [3:0] id, input logic w);
        return {st, rd, id, st == 3'd2, st == 3'd1, st == 3'd5, w};
    endfunction

    function automatic logic [14:0] dut_out();
        return {bus.state, bus.round, bus.seq_idx, bus.show, bus.setup_en, bus.done, bus.win};
    endfunction

    task automatic cmp(input string nm, input logic [14:0] act, input logic [14:0] exp,
                       input logic [14:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got %h want %h (mask %h)", nm, act & mask, exp & mask, mask);
        end
    endtask

    task automatic cyc(input string nm, input logic e, input logic t, input logic k,
                       input logic m, input logic [2:0] st, input logic [3:0] rd,
                       input logic [3:0] id, input logic w, input logic [14:0] mask);
        sb_t item;
        bus.enter    = e;
        bus.tick     = t;
        bus.user_key = k;
        bus.match    = m;
        sbq.push_back('{nm, pack(st, rd, id, w), mask});
        @(posedge clock);
        #1;
        bus.enter    = 1'b0;
        bus.tick     = 1'b0;
        bus.user_key = 1'b0;
        bus.match    = 1'b0;
        item = sbq.pop_front();
        cmp(item.name, dut_out(), item.exp, item.mask);
    endtask

    task automatic start_game();
        cyc("start_setup", 1, 0, 0, 0, 3'd1, 4'd0, 4'd0, 1'b0, state_m);
        cyc("start_show",  0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 1'b0, full_m);
    endtask

    task automatic go_idle();
        cyc("result_to_idle", 1, 0, 0, 0, 3'd0, 4'd0, 4'd0, 1'b0, state_m);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl = '{
            '{0,0,0,0, 3'd0, 4'd0, 4'd0, 1'b0},
            '{1,0,0,0, 3'd1, 4'd0, 4'd0, 1'b0},
            '{0,0,0,0, 3'd2, 4'd0, 4'd0, 1'b0},
            '{0,0,0,0, 3'd2, 4'd0, 4'd0, 1'b0},
            '{0,1,0,0, 3'd3, 4'd0, 4'd0, 1'b0},
            '{0,0,1,1, 3'd4, 4'd0, 4'd0, 1'b0},
            '{0,0,0,0, 3'd2, 4'd1, 4'd0, 1'b0},
            '{0,1,0,0, 3'd2, 4'd1, 4'd1, 1'b0},
            '{0,1,0,0, 3'd3, 4'd1, 4'd0, 1'b0},
            '{1,0,1,1, 3'd3, 4'd1, 4'd1, 1'b0},
            '{0,0,1,1, 3'd4, 4'd1, 4'd1, 1'b0},
            '{0,0,0,0, 3'd2, 4'd2, 4'd0, 1'b0},
            '{1,0,0,0, 3'd2, 4'd2, 4'd0, 1'b0},
            '{0,0,1,0, 3'd2, 4'd2, 4'd0, 1'b0},
            '{0,1,0,0, 3'd2, 4'd2, 4'd1, 1'b0},
            '{0,1,0,0, 3'd2, 4'd2, 4'd2, 1'b0},
            '{0,1,0,0, 3'd3, 4'd2, 4'd0, 1'b0},
            '{0,0,1,1, 3'd3, 4'd2, 4'd1, 1'b0},
            '{0,0,1,1, 3'd3, 4'd2, 4'd2, 1'b0},
            '{0,0,1,1, 3'd4, 4'd2, 4'd2, 1'b0},
            '{0,0,0,0, 3'd2, 4'd3, 4'd0, 1'b0},
            '{0,1,0,0, 3'd2, 4'd3, 4'd1, 1'b0},
            '{0,1,0,0, 3'd2, 4'd3, 4'd2, 1'b0},
            '{0,1,0,0, 3'd2, 4'd3, 4'd3, 1'b0},
            '{0,1,0,0, 3'd3, 4'd3, 4'd0, 1'b0},
            '{0,0,1,1, 3'd3, 4'd3, 4'd1, 1'b0},
            '{0,0,1,1, 3'd3, 4'd3, 4'd2, 1'b0},
            '{0,0,1,0, 3'd5, 4'd3, 4'd2, 1'b0},
            '{0,0,0,0, 3'd5, 4'd3, 4'd2, 1'b0},
            '{0,1,1,1, 3'd5, 4'd3, 4'd2, 1'b0}
        };

        reset               = 1'b1;
        bus.enter           = 1'b0;
        bus.tick            = 1'b0;
        bus.user_key        = 1'b0;
        bus.match           = 1'b0;
        bus.reg_setup_level = 2'd0;
        @(posedge clock);
        @(posedge clock);
        #1;
        cmp("reset_state", dut_out(), 15'h0000, full_m);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            cyc($sformatf("tbl[%0d]", i), tbl[i].e, tbl[i].t, tbl[i].k, tbl[i].m,
                tbl[i].st, tbl[i].rd, tbl[i].id, tbl[i].w, full_m);
        end
        go_idle();

        bus.reg_setup_level = 2'd2;
`ifdef GENIUS_TIMEOUT_EN
        start_game();
        cyc("to_input", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        for (int i = 0; i < 3; i++)
            cyc("tmo_wait", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        cyc("tmo_expire", 0, 1, 0, 0, 3'd5, 4'd0, 4'd0, 1'b0, full_m);
        go_idle();

        start_game();
        cyc("to_input", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        for (int i = 0; i < 3; i++)
            cyc("tmo_wait", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        cyc("key_tick_limit", 0, 1, 1, 1, 3'd4, 4'd0, 4'd0, 1'b0, full_m);
        cyc("next_show", 0, 0, 0, 0, 3'd2, 4'd1, 4'd0, 1'b0, full_m);
        cyc("show_tick", 0, 1, 0, 0, 3'd2, 4'd1, 4'd1, 1'b0, full_m);
        cyc("show_tick", 0, 1, 0, 0, 3'd3, 4'd1, 4'd0, 1'b0, full_m);
        for (int i = 0; i < 3; i++)
            cyc("tmo_wait", 0, 1, 0, 0, 3'd3, 4'd1, 4'd0, 1'b0, full_m);
        cyc("key_tick_clear", 0, 1, 1, 1, 3'd3, 4'd1, 4'd1, 1'b0, full_m);
        for (int i = 0; i < 3; i++)
            cyc("tmo_wait2", 0, 1, 0, 0, 3'd3, 4'd1, 4'd1, 1'b0, full_m);
        cyc("tmo_expire2", 0, 1, 0, 0, 3'd5, 4'd1, 4'd1, 1'b0, full_m);
        go_idle();
`else
        start_game();
        cyc("to_input", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        for (int i = 0; i < 10; i++)
            cyc("no_tmo_wait", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        cyc("mismatch", 0, 0, 1, 0, 3'd5, 4'd0, 4'd0, 1'b0, full_m);
        go_idle();
`endif

        bus.reg_setup_level = 2'd0;
        start_game();
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i <= r; i++) begin
                if (i < r)
                    cyc("win_show", 0, 1, 0, 0, 3'd2, 4'(r), 4'(i + 1), 1'b0, full_m);
                else
                    cyc("win_show_end", 0, 1, 0, 0, 3'd3, 4'(r), 4'd0, 1'b0, full_m);
            end
            for (int i = 0; i <= r; i++) begin
                if (i < r)
                    cyc("win_key", 0, 0, 1, 1, 3'd3, 4'(r), 4'(i + 1), 1'b0, full_m);
                else
                    cyc("win_key_last", 0, 0, 1, 1, 3'd4, 4'(r), 4'(r), 1'b0, full_m);
            end
            if (r == 14)
                cyc("win_final", 0, 0, 0, 0, 3'd5, 4'd15, 4'd0, 1'b1, full_m);
            else
                cyc("win_next", 0, 0, 0, 0, 3'd2, 4'(r + 1), 4'd0, 1'b0, full_m);
        end
        cyc("win_hold", 0, 1, 1, 0, 3'd5, 4'd15, 4'd0, 1'b1, full_m);
        go_idle();

        start_game();
        cyc("rst_to_input", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);
        cyc("rst_key",      0, 0, 1, 1, 3'd4, 4'd0, 4'd0, 1'b0, full_m);
        cyc("rst_next",     0, 0, 0, 0, 3'd2, 4'd1, 4'd0, 1'b0, full_m);
        cyc("rst_show",     0, 1, 0, 0, 3'd2, 4'd1, 4'd1, 1'b0, full_m);
        #3;
        reset = 1'b1;
        #1;
        cmp("async_reset", dut_out(), 15'h0000, full_m);
        @(posedge clock);
        #1;
        cmp("reset_hold", dut_out(), 15'h0000, full_m);
        reset = 1'b0;
        cyc("post_rst_idle", 0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 1'b0, full_m);
        cyc("post_rst_setup", 1, 0, 0, 0, 3'd1, 4'd0, 4'd0, 1'b0, full_m);
        cyc("post_rst_show", 0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 1'b0, full_m);
        cyc("post_rst_input", 0, 1, 0, 0, 3'd3, 4'd0, 4'd0, 1'b0, full_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/genius_control.md
# genius_control

Main sequencing FSM for the memory game. Loads setup, plays the growing sequence, collects and checks player presses against a per-level time limit, and produces `round`, the count of correctly repeated sequences. That count feeds the points calculation together with `reg_setup_level`. The block sits between the user input synchronizers, `Reg_setup`, the sequence ROM/display path and the scoring logic.

## Interface
Parameters:
- `p_round`, 4: width of `round` and `seq_idx`.
- `p_setup`, 2: width of `reg_setup_level`.
- `p_tmo`, 4: width of the internal timeout counter.

Ports:
- `clock`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `enter`, in, 1: one-cycle pulse, already debounced/synchronized.
- `tick`, in, 1: one-cycle pulse, nominally 1 Hz; paces display and timeout.
- `user_key`, in, 1: one-cycle pulse when the player presses any key.
- `match`, in, 1: valid only with `user_key`; 1 when the pressed key equals element `seq_idx`.
- `reg_setup_level`, in, 2: difficulty 0..3, sampled in INPUT.
- `round`, out, 4: sequences completed correctly.
- `seq_idx`, out, 4: sequence element currently shown or expected.
- `show`, out, 1: high in SHOW; display drives element `seq_idx`.
- `setup_en`, out, 1: one-cycle load strobe for `Reg_setup`.
- `state`, out, 3: encoded FSM state for debug/LEDs.
- `done`, out, 1: game over; high in RESULT.
- `win`, out, 1: valid with `done`; 1 = all sequences completed.

## Operation
- States and encodings: IDLE=0, SETUP=1, SHOW=2, INPUT=3, NEXT=4, RESULT=5. Codes 6 and 7 return to IDLE.
- **IDLE:** on `enter`, go to SETUP.
- **SETUP:**
  - `setup_en`=1 for exactly one cycle.
  - `round`<=0, `seq_idx`<=0, `win`<=0.
  - Go to SHOW.
- **SHOW:**
  - `show`=1.
  - On `tick`, if `seq_idx`==`round`: `seq_idx`<=0, go to INPUT.
  - On `tick` otherwise: `seq_idx`++.
  - Result: `round`+1 elements (indices 0..`round`) are shown, one per tick.
- **INPUT:**
  - Timeout counter clears on entry and on every `user_key`, and increments on `tick`.
  - Limit by `reg_setup_level`: 0→8, 1→6, 2→4, 3→2 ticks. Counter reaching the limit → RESULT with `win`=0.
  - `user_key`&`match`&(`seq_idx`==`round`) → NEXT.
  - `user_key`&`match` otherwise → `seq_idx`++.
  - `user_key`&!`match` → RESULT with `win`=0.
  - `user_key` and `tick` in the same cycle: the key is processed, the counter clears, and no timeout occurs.
- **NEXT:**
  - `round`<=`round`+1, `seq_idx`<=0.
  - If the old `round`==14 → RESULT with `win`=1, final `round`=15.
  - Otherwise → SHOW.
- **RESULT:**
  - `done`=1; `round` and `win` hold for scoring.
  - On `enter`, go to IDLE.
- `enter` is ignored in SETUP, SHOW, INPUT and NEXT.
- `user_key` is ignored outside INPUT.
- `round` never wraps; the maximum is 15.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Reset values: `state`=IDLE, `round`=0, `seq_idx`=0, `show`=0, `setup_en`=0, `done`=0, `win`=0, timeout counter=0.
- Each transition takes effect on the edge after the qualifying input is sampled.
- `enter` in IDLE → `setup_en` high the next cycle → SHOW the cycle after.
- SHOW lasts `round`+1 ticks. The first element displays immediately on entry.
- NEXT and SETUP each last exactly one cycle.
- Reset asserted mid-game returns to IDLE asynchronously; no partial `done`/`win` pulse is emitted.

## Configuration
- `GENIUS_TIMEOUT_EN` defined: the INPUT timeout counter and level limits are compiled in, as described above.
- `GENIUS_TIMEOUT_EN` undefined:
  - No counter logic; INPUT waits indefinitely and `tick` is ignored there.
  - RESULT with `win`=0 occurs only on a mismatch.
  - All other behaviour is identical.

## Test plan
- Reset, then `enter` → `setup_en` is a one-cycle pulse; `state` goes 0→1→2; `round`=0, `show`=1.
- Round 0: one `tick` → INPUT. Key with `match`=1 → NEXT, then SHOW with `round`=1. Two ticks in SHOW, `seq_idx` 0→1→0, then INPUT.
- Level 2, `GENIUS_TIMEOUT_EN` defined: no key for 4 ticks in INPUT → `done`=1, `win`=0, `round` unchanged.
- In INPUT with `round`=3: keys matching at idx 0, 1, then a mismatch → RESULT with `win`=0, `round`=3. `enter` → IDLE.
- Play 15 correct rounds → `done`=1, `win`=1, `round`=15. Also: `user_key` and `tick` in the same cycle at the limit-1 count → no timeout.
- Assert `reset` mid-SHOW → all outputs 0 and `state`=0 immediately; a later `enter` starts a clean game.
